datapath_sequencer: RTL and testbench

Programmable controller that drives the CPU datapath's control inputs: RegEnable, MuxControlA/B/C and AluControl. It replaces the fixed-pattern test FSMs with a small loadable microprogram of register-transfer, loop and halt instructions. It sits between the board-level top and `CPU_Datapath`, and connects to the datapath exactly as the FSM testers do. A start/busy/done handshake lets the top rerun the program without reprogramming.

---
 rtl/datapath_sequencer.sv | 155 +++++++++++++++
 tb/tb_datapath_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: loadable microprogram controller for CPU_Datapath.
// Each instruction is fetched from a small program RAM (FETCH) and then
// executed (EXECUTE). Only EXEC instructions drive the datapath controls, and
// only for their EXECUTE cycle. start/busy/done lets the board top rerun the
// stored program without reloading it.
module datapath_sequencer #(
  parameter int          PROG_DEPTH = 16,
  parameter logic [15:0] ALU_OP0    = 16'h0001,
  parameter logic [15:0] ALU_OP1    = 16'h0002,
  localparam int         PW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    loop_count,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  output logic [15:0]   RegEnable,
  output logic [3:0]    MuxControlA,
  output logic [3:0]    MuxControlB,
  output logic          MuxControlC,
  output logic [15:0]   AluControl,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_e;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_EXEC = 2'b01,
    OP_LOOP = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  // Datapath control bundle, registered so the datapath sees clean levels.
  typedef struct packed {
    logic [15:0] reg_en;
    logic [3:0]  mux_a;
    logic [3:0]  mux_b;
    logic        mux_c;
    logic [15:0] alu;
  } ctl_t;

  logic [15:0]   mem [PROG_DEPTH];
  logic [15:0]   rd_word;
  op_e           rd_op;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [7:0]    ctr_q, ctr_d;
  op_e           op_q;
  logic [3:0]    tgt_q;
  ctl_t          ctl_q, ctl_d;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] loop_tgt;

  // Program RAM write port: only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && state_q == S_IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign rd_word  = mem[pc_q];
  assign rd_op    = op_e'(rd_word[15:14]);
  assign pc_inc   = pc_q + PW'(1);
  assign loop_tgt = PW'(tgt_q);

  // Decode the word being fetched into the controls for the next cycle;
  // every other state loads zero, so controls live only in EXECUTE.
  always_comb begin
    ctl_d = '0;
    if (state_q == S_FETCH && rd_op == OP_EXEC) begin
      ctl_d.reg_en = 16'(1) << rd_word[13:10];
      ctl_d.mux_a  = rd_word[9:6];
      ctl_d.mux_b  = rd_word[5:2];
      ctl_d.mux_c  = rd_word[1];
      ctl_d.alu    = rd_word[0] ? ALU_OP1 : ALU_OP0;
    end
  end

  // Instruction register and control output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q  <= OP_NOP;
      tgt_q <= '0;
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      if (state_q == S_FETCH) begin
        op_q  <= rd_op;
        tgt_q <= rd_word[3:0];
      end
    end
  end

  // Sequencer state, program counter and loop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next-state logic: fetch/execute alternation, loop and halt handling.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          ctr_d   = loop_count;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op_q)
          OP_LOOP: begin
            if (ctr_q != 8'd0) begin
              ctr_d = ctr_q - 8'd1;
              pc_d  = loop_tgt;
            end else begin
              pc_d = pc_inc;
            end
          end
          OP_HALT: state_d = S_DONE;
          default: pc_d = pc_inc;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign RegEnable   = ctl_q.reg_en;
  assign MuxControlA = ctl_q.mux_a;
  assign MuxControlB = ctl_q.mux_b;
  assign MuxControlC = ctl_q.mux_c;
  assign AluControl  = ctl_q.alu;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign pc          = pc_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed vector table, hand sequences for
// guard/reset corners, and random programs against an instruction-level model.
module tb_datapath_sequencer;

  localparam logic [15:0] ALU0 = 16'h0001;
  localparam logic [15:0] ALU1 = 16'h0002;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  loop_count = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [15:0] RegEnable, AluControl;
  logic [3:0]  MuxControlA, MuxControlB, pc;
  logic        MuxControlC, busy, done;

  always #5 clk = ~clk;

  datapath_sequencer #(.PROG_DEPTH(16), .ALU_OP0(ALU0), .ALU_OP1(ALU1)) dut (
    .clk(clk), .reset(reset), .start(start), .loop_count(loop_count),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .RegEnable(RegEnable), .MuxControlA(MuxControlA), .MuxControlB(MuxControlB),
    .MuxControlC(MuxControlC), .AluControl(AluControl),
    .busy(busy), .done(done), .pc(pc)
  );

  typedef struct packed {
    logic [15:0] re;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
    logic [15:0] alu;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
  } obs_t;

  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2;
    int          lc;
    int          exp_done;
    int          exp_pulses;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] shadow [16];
  obs_t        exp_q [$];

  function automatic obs_t cur_obs();
    obs_t o;
    o.re = RegEnable; o.a = MuxControlA; o.b = MuxControlB; o.c = MuxControlC;
    o.alu = AluControl; o.busy = busy; o.done = done; o.pc = pc;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got re=%h a=%h b=%h c=%b alu=%h busy=%b done=%b pc=%h, wanted re=%h a=%h b=%h c=%b alu=%h busy=%b done=%b pc=%h",
               name, act.re, act.a, act.b, act.c, act.alu, act.busy, act.done, act.pc,
               exp.re, exp.a, exp.b, exp.c, exp.alu, exp.busy, exp.done, exp.pc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d wanted %0d", name, act, exp);
    end
  endtask

  // Instruction-level interpreter: each instruction contributes a fetch cycle
  // and an execute cycle; HALT adds the done cycle and the first idle cycle.
  task automatic model_build(input int lc);
    obs_t        o;
    int          mpc = 0;
    int          ctr = lc;
    logic [15:0] w;
    bit          fin = 0;
    exp_q.delete();
    for (int n = 0; n < 1500 && !fin; n++) begin
      w = shadow[mpc];
      o = '0; o.busy = 1'b1; o.pc = 4'(mpc);
      exp_q.push_back(o);
      if (w[15:14] == 2'b01) begin
        o.re = 16'h0001 << w[13:10];
        o.a = w[9:6]; o.b = w[5:2]; o.c = w[1];
        o.alu = w[0] ? ALU1 : ALU0;
      end
      exp_q.push_back(o);
      case (w[15:14])
        2'b10: begin
          if (ctr != 0) begin ctr--; mpc = int'(w[3:0]); end
          else mpc = (mpc + 1) % 16;
        end
        2'b11: begin
          o = '0; o.busy = 1'b1; o.done = 1'b1; o.pc = 4'(mpc);
          exp_q.push_back(o);
          o = '0; o.pc = 4'(mpc);
          exp_q.push_back(o);
          fin = 1;
        end
        default: mpc = (mpc + 1) % 16;
      endcase
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[3:0]; prog_data = d;
    shadow[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start a run and compare every cycle until the first idle cycle.
  // guard: drive prog_we/start while busy; wr_en: write mem[0] with start.
  task automatic run_trace(input string name, input int lc, input bit guard,
                           input bit wr_en, input logic [15:0] wr_data);
    if (wr_en) shadow[0] = wr_data;
    model_build(lc);
    @(negedge clk);
    start = 1'b1; loop_count = 8'(lc);
    if (wr_en) begin prog_we = 1'b1; prog_addr = 4'd0; prog_data = wr_data; end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; loop_count = 8'($urandom);
    foreach (exp_q[i]) begin
      chk($sformatf("%s cyc%0d", name, i + 1), cur_obs(), exp_q[i]);
      if (guard && i == 2) begin
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h7FFF; start = 1'b1;
      end else begin
        prog_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  vec_t tbl [7];

  initial begin
    obs_t        z, o;
    int          done_cyc, pulses, busy_after;
    int          len;
    logic [15:0] w;
    int          t;

    tbl[0] = '{"single",   16'h4C24, 16'hC000, 16'hC000, 0,  5, 1};
    tbl[1] = '{"loop3",    16'h4C24, 16'h8000, 16'hC000, 3, 19, 4};
    tbl[2] = '{"loop0",    16'h4C24, 16'h8000, 16'hC000, 0,  7, 1};
    tbl[3] = '{"loop1",    16'h4C24, 16'h8000, 16'hC000, 1, 11, 2};
    tbl[4] = '{"halt",     16'hC000, 16'hC000, 16'hC000, 5,  3, 0};
    tbl[5] = '{"nop_halt", 16'h0000, 16'hC000, 16'hC000, 0,  5, 0};
    tbl[6] = '{"exec_op1", 16'h7FFF, 16'hC000, 16'hC000, 0,  5, 1};

    z = '0;

    // Reset held with start high: nothing moves.
    reset = 1'b0; start = 1'b1;
    @(negedge clk); chk("reset cyc1", cur_obs(), z);
    @(negedge clk); chk("reset cyc2", cur_obs(), z);
    start = 1'b0; reset = 1'b1;

    // Directed table: done cycle, EXEC pulse count, busy after done.
    foreach (tbl[k]) begin
      load(0, tbl[k].p0); load(1, tbl[k].p1); load(2, tbl[k].p2);
      @(negedge clk);
      start = 1'b1; loop_count = 8'(tbl[k].lc);
      done_cyc = 0; pulses = 0; busy_after = -1;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (RegEnable != 16'h0) pulses++;
        if (done && done_cyc == 0) done_cyc = c;
        if (done_cyc != 0 && c == done_cyc + 1) begin
          busy_after = int'(busy);
          break;
        end
      end
      chk_int({tbl[k].name, " done_cycle"}, done_cyc, tbl[k].exp_done);
      chk_int({tbl[k].name, " exec_pulses"}, pulses, tbl[k].exp_pulses);
      chk_int({tbl[k].name, " busy_after_done"}, busy_after, 0);
    end

    // Full per-cycle traces of the basic programs.
    load(0, 16'h4C24); load(1, 16'hC000);
    run_trace("single_trace", 0, 0, 0, 16'h0);
    load(1, 16'h8000); load(2, 16'hC000);
    run_trace("loop3_trace", 3, 0, 0, 16'h0);
    run_trace("loop0_trace", 0, 0, 0, 16'h0);

    // Writes and start while busy are ignored; the run and mem[0] survive.
    load(1, 16'hC000);
    run_trace("guard_run", 0, 1, 0, 16'h0);
    run_trace("guard_after", 0, 0, 0, 16'h0);
    // Start and write together in idle: the new word is what gets fetched.
    run_trace("start_and_write", 0, 0, 1, 16'h5A5B);

    // pc wrap: LOOP to 14, NOPs at 14/15, wrap back to 0, fall to HALT.
    load(0, 16'h800E); load(1, 16'hC000); load(14, 16'h0000); load(15, 16'h0000);
    run_trace("pc_wrap", 1, 0, 0, 16'h0);

    // Reset during the EXECUTE cycle of the single-op program.
    load(0, 16'h4C24); load(1, 16'hC000);
    @(negedge clk); start = 1'b1; loop_count = 8'd0;
    @(negedge clk); start = 1'b0;
    o = '0; o.busy = 1'b1;
    chk("midreset cyc1", cur_obs(), o);
    @(negedge clk);
    o.re = 16'h0008; o.a = 4'd0; o.b = 4'd9; o.c = 1'b0; o.alu = 16'h0001;
    chk("midreset cyc2", cur_obs(), o);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset cyc3", cur_obs(), z);
    reset = 1'b1;
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("midreset quiet cyc%0d", c), cur_obs(), z);
    end
    run_trace("after_reset", 0, 0, 0, 16'h0);

    // Random programs: HALT last, loop targets inside the program.
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(2, 8);
      for (int i = 0; i < len; i++) begin
        w = 16'($urandom);
        t = (i == len - 1) ? 3 : $urandom_range(0, 3);
        w[15:14] = t[1:0];
        if (t == 2) begin
          t = $urandom_range(0, len - 1);
          w[3:0] = t[3:0];
        end
        load(i, w);
      end
      run_trace($sformatf("rand%0d", r), $urandom_range(0, 4), 0, 0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
